dm_access_ctrl: RTL and testbench

- Sequences every MEM-stage load and store onto a handshaked data-memory/bridge bus.
- Generates the word-aligned address, byte enables and lane-shifted write data for sw/sh/sb/swl/swr.
- Freezes the pipeline while a transaction is outstanding.
- Latches the returned word and hands the load-extension unit its raw word, DEXT opcode and low address bits.

---
 rtl/dm_access_ctrl_if.sv | 21 ++
 rtl/dm_access_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_if.sv
// Handshaked data-memory / bridge bus between the MEM-stage access
// controller (master) and the memory or bus bridge (slave).
interface dm_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller. Launches one bus transaction per
// aligned load/store, freezes the pipeline until it completes (or times out),
// flags misaligned accesses and hands the raw load word plus its DEXT opcode
// and low address bits to the load-extension unit.
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_rd,
    input  logic                    mem_wr,
    input  logic [2:0]              mem_op,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic                    stall,
    dm_access_ctrl_if.master        bus,
    output logic [31:0]             ld_data,
    output logic [2:0]              dext_op,
    output logic [1:0]              addr2,
    output logic                    ld_valid,
    output logic                    exc_adel,
    output logic                    exc_ades,
    output logic                    bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  timer;
    logic [2:0]  op_eff;
    logic        access;
    logic        misaligned;
    logic        stall_c;
    logic        timeout_hit;

    // Op 7 is undefined in the DEXT encoding; it behaves as a plain word access.
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        return (op == 3'd7) ? 3'd0 : op;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
        logic mis;
        case (op)
            3'd0:       mis = (a != 2'd0);
            3'd1, 3'd2: mis = a[0];
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte-lane enables; loads always fetch the whole word.
    function automatic logic [3:0] lane_be(input logic [2:0] op, input logic [1:0] a,
                                           input logic is_store);
        logic [3:0] be;
        if (!is_store) begin
            be = 4'b1111;
        end else begin
            case (op)
                3'd1, 3'd2: be = a[1] ? 4'b1100 : 4'b0011;
                3'd3, 3'd4: be = 4'b0001 << a;
                3'd5: begin
                    case (a)
                        2'd0:    be = 4'b0001;
                        2'd1:    be = 4'b0011;
                        2'd2:    be = 4'b0111;
                        default: be = 4'b1111;
                    endcase
                end
                3'd6: begin
                    case (a)
                        2'd0:    be = 4'b1111;
                        2'd1:    be = 4'b1110;
                        2'd2:    be = 4'b1100;
                        default: be = 4'b1000;
                    endcase
                end
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Replicate or shift the store data so each enabled lane carries its byte.
    function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] d);
        logic [31:0] w;
        case (op)
            3'd1, 3'd2: w = {2{d[15:0]}};
            3'd3, 3'd4: w = {4{d[7:0]}};
            3'd5: begin
                case (a)
                    2'd0:    w = {24'd0, d[31:24]};
                    2'd1:    w = {16'd0, d[31:16]};
                    2'd2:    w = {8'd0,  d[31:8]};
                    default: w = d;
                endcase
            end
            3'd6: begin
                case (a)
                    2'd0:    w = d;
                    2'd1:    w = {d[23:0], 8'd0};
                    2'd2:    w = {d[15:0], 16'd0};
                    default: w = {d[7:0],  24'd0};
                endcase
            end
            default: w = d;
        endcase
        return w;
    endfunction

    assign op_eff      = norm_op(mem_op);
    assign access      = mem_rd | mem_wr;
    assign misaligned  = is_misaligned(op_eff, addr[1:0]);
    assign timeout_hit = (state == REQ) && !bus.bus_ack && (timer == TIMER_LAST);

    // Held low during reset so the pipeline is never frozen while the controller is idle-forced.
    assign stall = stall_c & reset;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and combinational stall.
    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    stall_c  = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (bus.bus_ack || timeout_hit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bus launch/hold, load capture, timeout counting and one-cycle event pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_be    <= 4'd0;
            bus.bus_wdata <= 32'd0;
            ld_data       <= 32'd0;
            dext_op       <= 3'd0;
            addr2         <= 2'd0;
            ld_valid      <= 1'b0;
            exc_adel      <= 1'b0;
            exc_ades      <= 1'b0;
            bus_err       <= 1'b0;
            timer         <= 8'd0;
        end else begin
            ld_valid <= 1'b0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            exc_adel <= mem_rd;
                            exc_ades <= mem_wr;
                        end else begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_wr;
                            bus.bus_addr  <= {addr[31:2], 2'b00};
                            bus.bus_be    <= lane_be(op_eff, addr[1:0], mem_wr);
                            bus.bus_wdata <= lane_wdata(op_eff, addr[1:0], wdata);
                            dext_op       <= op_eff;
                            addr2         <= addr[1:0];
                            timer         <= 8'd0;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) begin
                            ld_data  <= bus.bus_rdata;
                            ld_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        bus.bus_req <= 1'b0;
                        bus_err     <= 1'b1;
                        ld_data     <= 32'd0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: table of load/store vectors driven through a
// simple slave model, bus requests and load results checked against
// scoreboard queues, plus hand-written timeout and mid-REQ reset sequences.
module tb_dm_access_ctrl;

    localparam int TMO = 4;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_stall;
        logic        exp_exc;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  op;
        logic [1:0]  a2;
    } ld_exp_t;

    logic        clk;
    logic        reset;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic [2:0]  dext_op;
    logic [1:0]  addr2;
    logic        ld_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;

    dm_access_ctrl_if bif ();

    dm_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_op   (mem_op),
        .addr     (addr),
        .wdata    (wdata),
        .stall    (stall),
        .bus      (bif),
        .ld_data  (ld_data),
        .dext_op  (dext_op),
        .addr2    (addr2),
        .ld_valid (ld_valid),
        .exc_adel (exc_adel),
        .exc_ades (exc_ades),
        .bus_err  (bus_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bus_exp_t bus_q[$];
    ld_exp_t  ld_q[$];

    vec_t vecs [0:12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Load-result scoreboard: every ld_valid pulse consumes one expectation.
    always @(negedge clk) begin
        ld_exp_t e;
        if (reset && ld_valid) begin
            if (ld_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ld_valid_unexpected: got pulse expected none");
            end else begin
                e = ld_q.pop_front();
                chk("ld_data", ld_data, e.data);
                chk("dext_op", 32'(dext_op), 32'(e.op));
                chk("addr2", 32'(addr2), 32'(e.a2));
            end
        end
    end

    task automatic run_vec(input vec_t v, output int stall_cnt, output int req_cnt,
                           output int err_cnt, output logic [31:0] done_ld);
        bus_exp_t   be_e;
        ld_exp_t    le;
        logic [68:0] snap;
        logic       done;
        stall_cnt = 0;
        req_cnt   = 0;
        err_cnt   = 0;
        done_ld   = '0;
        done      = 1'b0;
        snap      = '0;
        @(posedge clk); #1;
        mem_rd = v.rd;
        mem_wr = v.wr;
        mem_op = v.op;
        addr   = v.addr;
        wdata  = v.wdata;
        if (v.exp_exc) begin
            @(negedge clk);
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_bus_req", 32'(bif.bus_req), 32'd0);
            @(posedge clk); #1;
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            @(negedge clk);
            chk("exc_adel", 32'(exc_adel), 32'(v.rd));
            chk("exc_ades", 32'(exc_ades), 32'(v.wr));
            chk("mis_bus_req2", 32'(bif.bus_req), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("exc_pulse_end", {30'd0, exc_adel, exc_ades}, 32'd0);
            chk("mis_stall2", 32'(stall), 32'd0);
        end else begin
            if (v.waits < TMO) begin
                be_e.we    = v.wr;
                be_e.addr  = v.exp_addr;
                be_e.be    = v.exp_be;
                be_e.wdata = v.exp_wdata;
                bus_q.push_back(be_e);
                if (v.rd) begin
                    le.data = v.rdata;
                    le.op   = v.op;
                    le.a2   = v.addr[1:0];
                    ld_q.push_back(le);
                end
            end
            for (int c = 0; c < 40 && !done; c++) begin
                @(negedge clk);
                if (stall) stall_cnt++;
                if (bus_err) err_cnt++;
                if (bif.bus_req) begin
                    if (req_cnt == 0) begin
                        snap = {bif.bus_we, bif.bus_addr, bif.bus_be, bif.bus_wdata};
                    end else begin
                        chk("bus_stable",
                            {31'd0, snap == {bif.bus_we, bif.bus_addr, bif.bus_be, bif.bus_wdata}},
                            32'd1);
                    end
                    if (req_cnt == v.waits) begin
                        bif.bus_ack   = 1'b1;
                        bif.bus_rdata = v.rdata;
                        if (bus_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL bus_q_underflow: got request expected none");
                        end else begin
                            be_e = bus_q.pop_front();
                            chk("bus_we", 32'(bif.bus_we), 32'(be_e.we));
                            chk("bus_addr", bif.bus_addr, be_e.addr);
                            chk("bus_be", 32'(bif.bus_be), 32'(be_e.be));
                            if (be_e.we) chk("bus_wdata", bif.bus_wdata, be_e.wdata);
                        end
                    end
                    req_cnt++;
                end
                if (stall_cnt > 0 && !stall) begin
                    done    = 1'b1;
                    done_ld = ld_data;
                end
                @(posedge clk); #1;
                bif.bus_ack   = 1'b0;
                bif.bus_rdata = $urandom;
                if (done) begin
                    mem_rd = 1'b0;
                    mem_wr = 1'b0;
                end
            end
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL access_timeout: got no stall release expected release within 40 cycles");
                mem_rd = 1'b0;
                mem_wr = 1'b0;
            end else begin
                chk("stall_cycles", stall_cnt, v.exp_stall);
            end
        end
    endtask

    initial begin
        int          sc;
        int          rc;
        int          ec;
        logic [31:0] dl;
        vec_t        tv;

        //            rd wr op    addr          wdata         rdata         w  exp_addr      be       exp_wdata     st exc
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_1004, 4'b1111, 32'h0,        2, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'd3, 32'h0000_2003, 32'h0000_00A5, 32'h0,        3, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 5, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'd5, 32'h0000_0011, 32'h1122_3344, 32'h0,        0, 32'h0000_0010, 4'b0011, 32'h0000_1122, 2, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd6, 32'h0000_0011, 32'h1122_3344, 32'h0,        0, 32'h0000_0010, 4'b1110, 32'h2233_4400, 2, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'hCAFE_BABE, 32'h0,        0, 32'h0000_2000, 4'b1100, 32'hBABE_BABE, 2, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'd0, 32'h0000_3000, 32'h1234_5678, 32'h0,        1, 32'h0000_3000, 4'b1111, 32'h1234_5678, 3, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd2, 32'h0000_4002, 32'h0,        32'h89AB_CDEF, 2, 32'h0000_4000, 4'b1111, 32'h0,        4, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'd4, 32'h0000_0001, 32'h0000_005A, 32'h0,        0, 32'h0000_0000, 4'b0010, 32'h5A5A_5A5A, 2, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd5, 32'h0000_5007, 32'h0,        32'h0BAD_F00D, 1, 32'h0000_5004, 4'b1111, 32'h0,        3, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'd5, 32'h0000_0012, 32'hA1B2_C3D4, 32'h0,        0, 32'h0000_0010, 4'b0111, 32'h00A1_B2C3, 2, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd1, 32'h0000_1001, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'd0, 32'h0000_1002, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 3'd2, 32'h0000_0003, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        0, 1'b1};

        reset         = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_op        = 3'd0;
        addr          = 32'd0;
        wdata         = 32'd0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_dext_addr2", {27'd0, dext_op, addr2}, 32'd0);
        chk("rst_bus_addr_be", bif.bus_addr | 32'(bif.bus_be), 32'd0);
        chk("rst_pulses", {28'd0, ld_valid, exc_adel, exc_ades, bus_err}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i <= 12; i++) begin
            run_vec(vecs[i], sc, rc, ec, dl);
        end

        // Timeout: no ack ever, abort after TMO REQ cycles.
        tv = '{1'b1, 1'b0, 3'd0, 32'h0000_6000, 32'h0, 32'h0, 99, 32'h0000_6000, 4'b1111, 32'h0, TMO + 1, 1'b0};
        run_vec(tv, sc, rc, ec, dl);
        chk("tmo_req_cycles", rc, TMO);
        chk("tmo_bus_err", ec, 32'd1);
        chk("tmo_ld_data", dl, 32'd0);

        // Controller must be back in IDLE and accept a fresh access.
        tv = '{1'b1, 1'b0, 3'd0, 32'h0000_0008, 32'h0, 32'h7777_1111, 0, 32'h0000_0008, 4'b1111, 32'h0, 2, 1'b0};
        run_vec(tv, sc, rc, ec, dl);
        chk("post_tmo_ld", dl, 32'h7777_1111);

        // Asynchronous reset in the middle of REQ.
        @(posedge clk); #1;
        mem_rd = 1'b1;
        mem_op = 3'd0;
        addr   = 32'h0000_7000;
        @(negedge clk);
        chk("pre_rst_stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("pre_rst_bus_req", 32'(bif.bus_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        mem_rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        tv = '{1'b1, 1'b0, 3'd3, 32'h0000_0003, 32'h0, 32'h0000_00C3, 0, 32'h0000_0000, 4'b1111, 32'h0, 2, 1'b0};
        run_vec(tv, sc, rc, ec, dl);
        chk("lb_dext_op", 32'(dext_op), 32'd3);
        chk("lb_addr2", 32'(addr2), 32'd3);

        repeat (2) @(negedge clk);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("ld_q_empty", ld_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
